// File: rtl/muldiv_unit_if.sv
// Issue/response bundle between the ID/EX stage and muldiv_unit.
// master = issuing pipeline side, slave = the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, a, b,
    input  busy, done, div_zero, result, hi, lo
  );

  modport slave (
    input  start, funct, a, b,
    output busy, done, div_zero, result, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both operate on
// unsigned magnitudes over WIDTH RUN cycles, and a FIX cycle applies signs.
// MFHI/MFLO/MTHI/MTLO complete in one cycle from IDLE.
// Optional macro MULDIV_FAST_MUL_EN: multiplies skip RUN and compute the
// product with a single-cycle '*' (divide timing is unchanged).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  // Shared working register: mul = {partial product, multiplier},
  // div = {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] r_acc;
  // Multiplicand for mul, divisor for div.
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_q;   // product / quotient must be negated
  logic               r_neg_r;   // remainder must be negated
  logic               r_dz;      // current divide had b == 0
  logic [WIDTH-1:0]   r_a_raw;   // original a, returned in hi on divide-by-zero
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand decode: magnitudes and signs only matter for signed ops.
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
  assign w_a_neg  = w_signed & bus.a[WIDTH-1];
  assign w_b_neg  = w_signed & bus.b[WIDTH-1];
  assign w_mag_a  = w_a_neg ? -bus.a : bus.a;
  assign w_mag_b  = w_b_neg ? -bus.b : bus.b;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = (2*WIDTH)'(w_mag_a) * (2*WIDTH)'(w_mag_b);
`endif

  // One shift-add multiply step: conditionally add multiplicand to the upper
  // half, then shift the whole register right (carry enters at the top).
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring divide step: shift next dividend bit into the remainder,
  // trial-subtract the divisor, keep the difference if it did not borrow.
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = w_div_sh - {1'b0, r_opnd};
  assign w_div_next = w_div_diff[WIDTH]
                    ? {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // Control FSM plus datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_a_raw    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_result   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.funct)
              F_MFHI: begin
                r_result <= r_hi;
                r_done   <= 1'b1;
              end
              F_MFLO: begin
                r_result <= r_lo;
                r_done   <= 1'b1;
              end
              F_MTHI: begin
                r_hi   <= bus.a;
                r_done <= 1'b1;
              end
              F_MTLO: begin
                r_lo   <= bus.a;
                r_done <= 1'b1;
              end
              F_MULT, F_MULTU: begin
                r_opnd   <= w_mag_a;
                r_is_div <= 1'b0;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= 1'b0;
                r_dz     <= 1'b0;
                r_a_raw  <= bus.a;
                r_cnt    <= CW'(WIDTH);
                r_busy   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                r_acc    <= w_fast_prod;
                r_state  <= S_FIX;
`else
                r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                r_state  <= S_RUN;
`endif
              end
              F_DIV, F_DIVU: begin
                r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                r_opnd   <= w_mag_b;
                r_is_div <= 1'b1;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_dz     <= (bus.b == '0);
                r_a_raw  <= bus.a;
                r_cnt    <= CW'(WIDTH);
                r_busy   <= 1'b1;
                r_state  <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_is_div && r_dz) begin
            r_lo <= '1;
            r_hi <= r_a_raw;
          end else if (r_is_div) begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end else begin
            r_lo <= w_prod[WIDTH-1:0];
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
          end
          r_div_zero <= r_is_div & r_dz;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_cnt      <= '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.result   = r_result;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/result
// from an arithmetic reference model; a negedge monitor pops on each done.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [5:0] F_MFHI = 6'd16, F_MTHI = 6'd17, F_MFLO = 6'd18,
                         F_MTLO = 6'd19, F_MULT = 6'd24, F_MULTU = 6'd25,
                         F_DIV  = 6'd26, F_DIVU = 6'd27;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] res;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] m_hi = '0, m_lo = '0, m_res = '0;
  logic         m_dz = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain SV arithmetic over the architectural state.
  task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit v, output int lat);
    logic signed [W-1:0] sa, sb;
    longint sp;
    logic [63:0] up;
    sa = a; sb = b; v = 1'b1; m_dz = 1'b0;
    lat = W + 2;
    case (f)
      F_MFHI: begin m_res = m_hi; lat = 1; end
      F_MFLO: begin m_res = m_lo; lat = 1; end
      F_MTHI: begin m_hi = a; lat = 1; end
      F_MTLO: begin m_lo = a; lat = 1; end
      F_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {m_hi, m_lo} = sp;
`ifdef MULDIV_FAST_MUL_EN
        lat = 2;
`endif
      end
      F_MULTU: begin
        up = 64'(a) * 64'(b);
        {m_hi, m_lo} = up;
`ifdef MULDIV_FAST_MUL_EN
        lat = 2;
`endif
      end
      F_DIV: begin
        if (b == '0) begin m_lo = '1; m_hi = a; m_dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = '0; end
        else begin m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
      end
      F_DIVU: begin
        if (b == '0) begin m_lo = '1; m_hi = a; m_dz = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      default: begin v = 1'b0; lat = 1; end
    endcase
  endtask

  task automatic push_exp(input int lat);
    exp_t e;
    e.hi = m_hi; e.lo = m_lo; e.res = m_res; e.dz = m_dz; e.cyc = cyc + lat;
    q.push_back(e);
  endtask

  // Issue one op (called just after a negedge), return in its done cycle.
  task automatic op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    bit v; int lat;
    bus.start = 1'b1; bus.funct = f; bus.a = a; bus.b = b;
    model(f, a, b, v, lat);
    if (v) push_exp(lat);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      chk("busy", 64'(bus.busy), 64'(v && lat > 1 && i < lat));
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return W'($urandom_range(0, 20));
      5: return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("dz_pulse", 64'(bus.div_zero & ~bus.done), 64'd0);
      if (bus.done) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("hi", 64'(bus.hi), 64'(e.hi));
          chk("lo", 64'(bus.lo), 64'(e.lo));
          chk("result", 64'(bus.result), 64'(e.res));
          chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
        end
      end
    end
  end

  initial begin
    logic [5:0] codes [9];
    logic [5:0] f;
    codes = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, 6'd20};
    rst_n = 1'b0; bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dz", 64'(bus.div_zero), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed cases from the boundary list.
    op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op(F_MULT, 32'hFFFF_FFFD, 32'd5);
    op(F_MFLO, 32'd0, 32'd0);
    op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    op(F_DIVU, 32'd10, 32'd0);
    op(F_DIV, 32'hFFFF_FFF0, 32'd0);
    op(F_MTHI, 32'h1234_5678, 32'd0);
    op(F_MFHI, 32'd0, 32'd0);
    op(6'd0, 32'hDEAD_BEEF, 32'd1);     // undecoded: ignored
    op(F_MFLO, 32'd0, 32'd0);

    // DIVU with a MULT strobe during RUN that must be dropped.
    bus.start = 1'b1; bus.funct = F_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    begin
      bit v; int lat;
      model(F_DIVU, 32'd100, 32'd7, v, lat);
      push_exp(lat);
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk);
        if (i == 1) bus.start = 1'b0;
        if (i == 5) begin bus.start = 1'b1; bus.funct = F_MULT; bus.a = 32'd3; bus.b = 32'd5; end
        if (i == 6) bus.start = 1'b0;
        chk("busy_drop", 64'(bus.busy), 64'(i < lat));
      end
    end
    op(F_MTLO, 32'hCAFE_0001, 32'd0);     // issued in the done cycle
    op(F_MFLO, 32'd0, 32'd0);

    // Randomized mix, back-to-back.
    for (int n = 0; n < 40; n++) begin
      f = codes[$urandom_range(0, 8)];
      op(f, rnd_val(), rnd_val());
    end

    // Reset mid-operation: no done, hi/lo cleared.
    op(F_MTHI, 32'h5555_AAAA, 32'd0);
    op(F_MTLO, 32'hAAAA_5555, 32'd0);
    bus.start = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
    bus.funct = F_DIVU;
`else
    bus.funct = F_MULTU;
`endif
    bus.a = 32'hFFFF_FFFF; bus.b = 32'd3;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 10) rst_n = 1'b0;
      if (i == 11) begin
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_hi", 64'(bus.hi), 64'd0);
        chk("rst_mid_lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;
      end
    end
    m_hi = '0; m_lo = '0; m_res = '0;
    op(F_MFHI, 32'd0, 32'd0);
    op(F_DIV, 32'd7, 32'hFFFF_FFFE);

    repeat (3) @(negedge clk);
    chk("pending", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with its own HI/LO register pair. It replaces the single-cycle `MUL` function-code path of the ALU decode. The ID/EX stage issues R-format `Funct` codes `MULT`/`MULTU`/`DIV`/`DIVU`/`MFHI`/`MFLO`/`MTHI`/`MTLO` with a `start` strobe. The unit runs a shift-add multiply or restoring divide over `WIDTH` cycles, and holds `busy` so hazard logic stalls dependent `MFHI`/`MFLO`.

## Interface
- `WIDTH`, 32: operand, HI, LO and result width; must be ≥ 4 and even.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  issue strobe, sampled each rising edge.
- `funct`  in  6  R-format function code, valid with `start`.
- `a`  in  WIDTH  rs operand: dividend / multiplicand / MT source.
- `b`  in  WIDTH  rt operand: divisor / multiplier.
- `busy`  out  1  registered; high while a multiply or divide is in flight.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  high with `done` when a `DIV`/`DIVU` had `b`=0.
- `result`  out  WIDTH  `MFHI`/`MFLO` read data, registered.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- Decoded codes: `MFHI`=16, `MTHI`=17, `MFLO`=18, `MTLO`=19, `MULT`=24, `MULTU`=25, `DIV`=26, `DIVU`=27.
- Any other `funct` with `start` is ignored: no state change, no `done`.
- FSM states: `IDLE`, `RUN`, `FIX`.
- `start` is honoured only in `IDLE`. Any `start` during `RUN`/`FIX` is dropped.
- `IDLE` + mul/div start: latch operand magnitudes and result sign (signed ops only); counter←`WIDTH`; go to `RUN`.
- `RUN`, multiply: one add/shift step per cycle.
- `RUN`, divide: one restoring-division step per cycle on the unsigned magnitudes.
- `RUN`: counter decrements each cycle. Counter 1 → go to `FIX`.
- `FIX`: apply sign correction.
  - Signed product: negate the 2·`WIDTH` product when signs differ.
  - Signed quotient: negative iff signs differ.
  - Signed remainder: takes the sign of `a`.
- `FIX` end: write hi←upper half / remainder, lo←lower half / quotient; set `done`; return to `IDLE`.
- Divide by zero: lo←all ones, hi←`a` unchanged, `div_zero`=1. Identical for `DIV` and `DIVU`, no sign fix.
- Signed overflow (`DIV` of MIN by −1): lo←MIN, hi←0. This is the natural result of the magnitude algorithm.
- `MFHI`/`MFLO` in `IDLE`: result←hi/lo; `done` next cycle.
- `MTHI`/`MTLO` in `IDLE`: hi/lo←`a`; `done` next cycle; `result` unchanged.
- Reset: `rst_n` low at an edge forces `IDLE` and zeroes `busy`, `done`, `div_zero`, `result`, `hi`, `lo` and the counter.
- Reset mid-`RUN` abandons the operation with no `done`.

## Timing
- Cycle 0 is the cycle in which `start` is high in `IDLE`.
- Mul/div: `busy`=1 in cycles 1..`WIDTH`+1. `done`=1 and hi/lo valid in cycle `WIDTH`+2, with `busy`=0.
- `done` cycle is `IDLE`: a `start` in that cycle is accepted, giving back-to-back operations every `WIDTH`+2 cycles.
- `MF*`/`MT*`: `done` in cycle 1, `busy` never asserted; back-to-back each cycle allowed.
- `done`, `div_zero`: single-cycle pulses, 0 otherwise.
- hi/lo change only at the `FIX` exit edge or an `MT*` edge.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - `MULT`/`MULTU` skip `RUN`. Cycle 1 is `FIX`, using a single-cycle `*` on the magnitudes.
  - `busy` only in cycle 1; `done` in cycle 2.
  - Divide timing is unchanged.
- Undefined: iterative multiply as above. Functional results are identical either way.

## Test plan
- `MULTU` a=0xFFFFFFFF b=0xFFFFFFFF → cycle 34: `done`=1, hi=0xFFFFFFFE, lo=0x00000001, `busy` high cycles 1–33 (cycle 2 / cycle 1 with `MULDIV_FAST_MUL_EN`).
- `MULT` a=0xFFFFFFFD (−3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; then `MFLO` → `result`=0xFFFFFFF1 in the following cycle.
- `DIV` a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. `DIV` a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- `DIVU` a=10 b=0 → lo=0xFFFFFFFF, hi=0x0000000A, `div_zero`=1 for exactly one cycle.
- `MTHI` a=0x12345678 → hi=0x12345678 in cycle 1.
  - A `DIVU` 100/7 started, with `MULT` strobed in cycle 5 → the strobe is ignored; lo=14, hi=2 at cycle 34.
  - A `start` in the `done` cycle is accepted.
- `MULTU` started, `rst_n` low in cycle 10 → cycle 11: `busy`=0, hi=lo=0, no `done` in cycle 34.
